// File: rtl/ascon_ti_pkg.sv
// ascon_ti_pkg: constants, round constant, FSM states and the 3-share TI substitution share function
package ascon_ti_pkg;
    localparam int ROUNDS_MAX = 12;
    localparam int STATE_W = 320;
    localparam int WORD_W = 64;
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};
    typedef enum logic [1:0] {IDLE, SUB, LIN, DONE} state_t;
    function automatic logic [7:0] rc(input logic [3:0] i);
        return {4'hF - i, i};
    endfunction
    function automatic logic [WORD_W-1:0] ror64(input logic [WORD_W-1:0] w, input int n);
        return (w >> n) | (w << (WORD_W - n));
    endfunction
    // Output share i sees only input shares i and i+1, so each share function stays non-complete
    function automatic logic [STATE_W-1:0] ti_chi_share(input logic [STATE_W-1:0] own,
                                                        input logic [STATE_W-1:0] nxt,
                                                        input logic inv);
        logic [WORD_W-1:0] a [5];
        logic [WORD_W-1:0] b [5];
        logic [WORD_W-1:0] y [5];
        for (int k = 0; k < 5; k++) begin
            a[k] = own[STATE_W-1-WORD_W*k -: WORD_W];
            b[k] = nxt[STATE_W-1-WORD_W*k -: WORD_W];
        end
        a[0] ^= a[4]; a[4] ^= a[3]; a[2] ^= a[1];
        b[0] ^= b[4]; b[4] ^= b[3]; b[2] ^= b[1];
        for (int k = 0; k < 5; k++)
            y[k] = a[k] ^ (~a[(k+1)%5] & a[(k+2)%5]) ^ (a[(k+1)%5] & b[(k+2)%5]) ^ (b[(k+1)%5] & a[(k+2)%5]);
        y[1] ^= y[0]; y[0] ^= y[4]; y[3] ^= y[2];
        y[2] = inv ? ~y[2] : y[2];
        return {y[0], y[1], y[2], y[3], y[4]};
    endfunction
endpackage

// File: rtl/ascon_ti_perm_ctrl_lin.sv
// ascon_lin_layer: Ascon linear diffusion layer applied to a single share
module ascon_lin_layer
    import ascon_ti_pkg::*;
(
    input  logic [STATE_W-1:0] i_x,
    output logic [STATE_W-1:0] o_y
);
    for (genvar j = 0; j < 5; j++) begin : g_w
        logic [WORD_W-1:0] w_w;
        assign w_w = i_x[STATE_W-1-WORD_W*j -: WORD_W];
        assign o_y[STATE_W-1-WORD_W*j -: WORD_W] = w_w ^ ror64(w_w, ROT_A[j]) ^ ror64(w_w, ROT_B[j]);
    end
endmodule

// File: rtl/ascon_ti_perm_ctrl.sv
// ascon_ti_perm_ctrl: multi-round sequencer for the 3-share TI Ascon permutation
module ascon_ti_perm_ctrl
    import ascon_ti_pkg::*;
#(
    parameter int RW = STATE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               ready,
    input  logic [3:0]         rounds,
    input  logic [STATE_W-1:0] s0_in,
    input  logic [STATE_W-1:0] s1_in,
    input  logic [STATE_W-1:0] s2_in,
    input  logic [RW-1:0]      rnd,
    input  logic               rnd_valid,
    output logic               rnd_ready,
    output logic [STATE_W-1:0] s0_out,
    output logic [STATE_W-1:0] s1_out,
    output logic [STATE_W-1:0] s2_out,
    output logic               out_valid,
    input  logic               out_ready
);
    localparam int HW = RW / 2;
    state_t r_state, w_state_nxt;
    logic [3:0] r_i, w_rounds, w_i0;
    logic [STATE_W-1:0] r_s0, r_s1, r_s2, r_t0, r_t1, r_t2;
    logic [STATE_W-1:0] w_a, w_b, w_m0, w_m1, w_m2, w_l0, w_l1, w_l2, w_rcv;
    logic [HW-1:0] w_r0, w_r1;
    assign w_rounds = (rounds == 4'd0 || rounds > 4'(ROUNDS_MAX)) ? 4'(ROUNDS_MAX) : rounds;
    assign w_i0 = 4'(ROUNDS_MAX) - w_rounds;
    assign w_r0 = rnd[RW-1:HW];
    assign w_r1 = rnd[HW-1:0];
    assign w_a = {w_r0[63:0], w_r0[63:0], w_r0[127:64], w_r0[127:64], w_r0[159:128], w_r0[159:128]};
    assign w_b = {w_r1[63:0], w_r1[63:0], w_r1[127:64], w_r1[127:64], w_r1[159:128], w_r1[159:128]};
    assign w_rcv = STATE_W'(rc(r_i)) << (2 * WORD_W);
    // Refresh keeps the share sum intact: a, b and a^b cancel across the three shares
    assign w_m0 = r_s0 ^ w_a ^ w_rcv;
    assign w_m1 = r_s1 ^ w_b;
    assign w_m2 = r_s2 ^ w_a ^ w_b;
    ascon_lin_layer u_lin0 (.i_x(r_t0), .o_y(w_l0));
    ascon_lin_layer u_lin1 (.i_x(r_t1), .o_y(w_l1));
    ascon_lin_layer u_lin2 (.i_x(r_t2), .o_y(w_l2));
    assign ready = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign rnd_ready = r_state == SUB && rnd_valid;
    assign s0_out = r_s0;
    assign s1_out = r_s1;
    assign s2_out = r_s2;
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = start ? SUB : IDLE;
            SUB:     w_state_nxt = rnd_valid ? LIN : SUB;
            LIN:     w_state_nxt = (r_i == 4'(ROUNDS_MAX - 1)) ? DONE : SUB;
            DONE:    w_state_nxt = out_ready ? IDLE : DONE;
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_i <= '0;
            r_s0 <= '0;
            r_s1 <= '0;
            r_s2 <= '0;
            r_t0 <= '0;
            r_t1 <= '0;
            r_t2 <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && start) begin
                r_s0 <= s0_in;
                r_s1 <= s1_in;
                r_s2 <= s2_in;
                r_i <= w_i0;
            end
            // Registered barrier after the share functions stops glitches from recombining shares
            if (r_state == SUB && rnd_valid) begin
                r_t0 <= ti_chi_share(w_m0, w_m1, 1'b1);
                r_t1 <= ti_chi_share(w_m1, w_m2, 1'b0);
                r_t2 <= ti_chi_share(w_m2, w_m0, 1'b0);
            end
            if (r_state == LIN) begin
                r_s0 <= w_l0;
                r_s1 <= w_l1;
                r_s2 <= w_l2;
                r_i <= r_i + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_ascon_ti_perm_ctrl.sv
// tb_ascon_ti_perm_ctrl: randomized bench against a table-driven unmasked Ascon reference
module tb_ascon_ti_perm_ctrl;
    localparam logic [4:0] SBOX [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                         5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                         5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                         5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    logic clk = 0, rst_n = 0, start = 0, rnd_valid = 0, out_ready = 0;
    logic [3:0] rounds = 0;
    logic [319:0] s0_in = 0, s1_in = 0, s2_in = 0, rnd = 0;
    logic ready, rnd_ready, out_valid;
    logic [319:0] s0_out, s1_out, s2_out;
    int n_chk = 0, n_fail = 0;
    ascon_ti_perm_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .rounds(rounds),
        .s0_in(s0_in), .s1_in(s1_in), .s2_in(s2_in), .rnd(rnd), .rnd_valid(rnd_valid),
        .rnd_ready(rnd_ready), .s0_out(s0_out), .s1_out(s1_out), .s2_out(s2_out),
        .out_valid(out_valid), .out_ready(out_ready)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int k = 0; k < 10; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction
    function automatic logic [63:0] rr(input logic [63:0] w, input int n);
        logic [127:0] d;
        d = {w, w} >> n;
        return d[63:0];
    endfunction
    function automatic logic [319:0] ascon_p(input logic [319:0] s, input int nr);
        logic [63:0] x [5];
        logic [4:0] v;
        for (int k = 0; k < 5; k++) x[k] = s[319-64*k -: 64];
        for (int i = 12 - nr; i < 12; i++) begin
            x[2][7:0] = x[2][7:0] ^ {4'(15 - i), 4'(i)};
            for (int b = 0; b < 64; b++) begin
                v = SBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
                {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]} = v;
            end
            x[0] = x[0] ^ rr(x[0], 19) ^ rr(x[0], 28);
            x[1] = x[1] ^ rr(x[1], 61) ^ rr(x[1], 39);
            x[2] = x[2] ^ rr(x[2], 1) ^ rr(x[2], 6);
            x[3] = x[3] ^ rr(x[3], 10) ^ rr(x[3], 17);
            x[4] = x[4] ^ rr(x[4], 7) ^ rr(x[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction
    task automatic run_perm(input string tag, input logic [3:0] r, input logic [319:0] a, input bit split,
                            input bit zero_rnd, input int stall_at, input int stall_len, input int hold);
        int nr, cyc, hs, exp_lat;
        logic [319:0] m1, m2, c0, c1, c2;
        nr = (r == 0 || r > 12) ? 12 : int'(r);
        exp_lat = 2 * nr + ((stall_at >= 0 && stall_at < 2 * nr) ? stall_len : 0);
        m1 = split ? rand320() : '0;
        m2 = split ? rand320() : '0;
        s0_in = a ^ m1 ^ m2; s1_in = m1; s2_in = m2; rounds = r; start = 1; out_ready = 0;
        chk({tag, "/ready_idle"}, 320'(ready), 320'(1));
        @(posedge clk); #1;
        start = 0; cyc = 0; hs = 0;
        while (!out_valid && cyc < 200) begin
            rnd = zero_rnd ? '0 : rand320();
            rnd_valid = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + stall_len);
            #1;
            if (rnd_ready) hs++;
            @(posedge clk); #1;
            cyc++;
        end
        rnd_valid = 0;
        chk({tag, "/latency"}, 320'(cyc), 320'(exp_lat));
        chk({tag, "/rnd_used"}, 320'(hs), 320'(nr));
        chk({tag, "/result"}, s0_out ^ s1_out ^ s2_out, ascon_p(a, nr));
        c0 = s0_out; c1 = s1_out; c2 = s2_out;
        start = 1;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk({tag, "/hold_valid"}, 320'(out_valid), 320'(1));
            chk({tag, "/hold_ready"}, 320'(ready), 320'(0));
            chk({tag, "/hold_s0"}, s0_out, c0);
            chk({tag, "/hold_s1"}, s1_out, c1);
            chk({tag, "/hold_s2"}, s2_out, c2);
        end
        start = 0; out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk({tag, "/exit_ready"}, 320'(ready), 320'(1));
        chk({tag, "/exit_valid"}, 320'(out_valid), 320'(0));
    endtask
    initial begin
        logic [319:0] a;
        int r, sa;
        a = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0, 64'hdeadbeefcafebabe, 64'h1};
        rnd_valid = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst/ready", 320'(ready), 320'(1));
        chk("rst/valid", 320'(out_valid), 320'(0));
        chk("rst/rnd_ready", 320'(rnd_ready), 320'(0));
        chk("rst/s0", s0_out, '0);
        rnd_valid = 0;
        rst_n = 1;
        @(posedge clk); #1;
        run_perm("p12_plain", 4'd12, a, 0, 1, -1, 0, 0);
        run_perm("p6", 4'd6, a, 1, 0, -1, 0, 0);
        run_perm("p8", 4'd8, a, 1, 0, -1, 0, 0);
        run_perm("stall", 4'd12, a, 1, 0, 6, 3, 0);
        run_perm("r0", 4'd0, a, 1, 0, -1, 0, 0);
        run_perm("r13", 4'd13, a, 1, 0, -1, 0, 0);
        s0_in = rand320(); s1_in = rand320(); s2_in = rand320(); rounds = 4'd12; start = 1;
        @(posedge clk); #1;
        start = 0; rnd_valid = 1;
        repeat (8) begin
            rnd = rand320();
            @(posedge clk); #1;
        end
        rst_n = 0;
        #1;
        chk("midrst/ready", 320'(ready), 320'(1));
        chk("midrst/valid", 320'(out_valid), 320'(0));
        chk("midrst/rnd_ready", 320'(rnd_ready), 320'(0));
        chk("midrst/s1", s1_out, '0);
        rnd_valid = 0;
        @(posedge clk); #1;
        rst_n = 1;
        run_perm("after_rst", 4'd5, rand320(), 1, 0, -1, 0, 0);
        run_perm("hold", 4'd3, rand320(), 1, 0, -1, 0, 10);
        for (int n = 0; n < 6; n++) begin
            r = int'($urandom_range(1, 12));
            sa = 2 * int'($urandom_range(0, r - 1));
            run_perm("rand", 4'(r), rand320(), 1, 0, sa, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
